uart_cmd_decoder: RTL and testbench

Host-to-analyzer path: the receive counterpart of the FIFO-to-UART transmit controller. It drains bytes from the UART receiver, parses fixed 4-byte command frames and updates the trigger/readout configuration registers. It also issues arm and abort pulses to the capture logic.

---
 rtl/uart_cmd_decoder.sv | 135 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Host command path: pulls bytes from the UART receiver, parses A5/CMD/DATA/CHK frames and
// updates trigger/readout configuration, or issues arm/abort pulses to the capture logic.
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] UART_rx_data,
    input  logic       UART_rx_empty,
    output logic       UART_uld_rx_data,
    output logic       UART_rx_enable,
    output logic [2:0] triggerBlock_Mask,
    output logic [7:0] triggerBlock_Pattern,
    output logic [7:0] sample_div,
    output logic [1:0] Bit_Padder_Sel,
    output logic       arm_pulse,
    output logic       abort_pulse,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic [3:0] state_debug
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_ULD  = 4'd1,
        S_CAP  = 4'd2,
        S_CMD  = 4'd3,
        S_DAT  = 4'd4,
        S_CHK  = 4'd5,
        S_EXEC = 4'd6,
        S_ERR  = 4'd7
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [1:0]    r_slot;
    logic [1:0]    w_slot_next;
    logic [7:0]    r_cmd;
    logic [7:0]    r_data;
    logic [TW-1:0] r_tmo;
    logic [2:0]    r_mask;
    logic [7:0]    r_pattern;
    logic [7:0]    r_div;
    logic [1:0]    r_pad;

    logic w_waiting;
    logic w_timeout;
    logic w_cmd_ok;
    logic w_chk_ok;

    // Timeout only runs while a frame is partially received and the receiver is dry.
    assign w_waiting = ((r_state == S_CMD) || (r_state == S_DAT) || (r_state == S_CHK)) &&
                       UART_rx_empty;
    assign w_timeout = w_waiting && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_cmd_ok  = (r_cmd >= 8'h01) && (r_cmd <= 8'h06);
    assign w_chk_ok  = (UART_rx_data == (r_cmd ^ r_data));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_slot    <= 2'd0;
            r_cmd     <= 8'h00;
            r_data    <= 8'h00;
            r_tmo     <= '0;
            r_mask    <= 3'd0;
            r_pattern <= 8'h00;
            r_div     <= 8'd1;
            r_pad     <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_slot  <= w_slot_next;
            r_tmo   <= w_waiting ? (r_tmo + TW'(1)) : '0;
            if (r_state == S_CAP && r_slot == 2'd1) r_cmd  <= UART_rx_data;
            if (r_state == S_CAP && r_slot == 2'd2) r_data <= UART_rx_data;
            if (r_state == S_EXEC) begin
                case (r_cmd)
                    8'h01:   r_mask    <= r_data[2:0];
                    8'h02:   r_pattern <= r_data;
                    8'h03:   r_div     <= (r_data == 8'h00) ? 8'd1 : r_data;
                    8'h04:   r_pad     <= r_data[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        unique case (r_state)
            S_IDLE, S_CMD, S_DAT, S_CHK: begin
                if (!UART_rx_empty) begin
                    w_state_next = S_ULD;
                    case (r_state)
                        S_IDLE:  w_slot_next = 2'd0;
                        S_CMD:   w_slot_next = 2'd1;
                        S_DAT:   w_slot_next = 2'd2;
                        default: w_slot_next = 2'd3;
                    endcase
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end
            end
            S_ULD: w_state_next = S_CAP;
            S_CAP: begin
                case (r_slot)
                    2'd0:    w_state_next = (UART_rx_data == HEADER_BYTE) ? S_CMD : S_IDLE;
                    2'd1:    w_state_next = S_DAT;
                    2'd2:    w_state_next = S_CHK;
                    default: w_state_next = (w_chk_ok && w_cmd_ok) ? S_EXEC : S_ERR;
                endcase
            end
            S_EXEC, S_ERR: w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        UART_uld_rx_data     = (r_state == S_ULD);
        UART_rx_enable       = 1'b1;
        triggerBlock_Mask    = r_mask;
        triggerBlock_Pattern = r_pattern;
        sample_div           = r_div;
        Bit_Padder_Sel       = r_pad;
        arm_pulse            = (r_state == S_EXEC) && (r_cmd == 8'h05);
        abort_pulse          = (r_state == S_EXEC) && (r_cmd == 8'h06);
        cmd_done             = (r_state == S_EXEC);
        cmd_err              = (r_state == S_ERR);
        state_debug          = r_state;
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: queue-based UART receiver, directed frame table, corner-case
// sequences and random frame streams checked against a byte-level frame parser model.
module tb_uart_cmd_decoder;

    localparam int unsigned TMO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       uld, rx_en, arm, abort, done, err;
    logic [2:0] mask;
    logic [7:0] pat, div;
    logic [1:0] pad;
    logic [3:0] state;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .HEADER_BYTE   (8'hA5)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .UART_rx_data        (rx_data),
        .UART_rx_empty       (rx_empty),
        .UART_uld_rx_data    (uld),
        .UART_rx_enable      (rx_en),
        .triggerBlock_Mask   (mask),
        .triggerBlock_Pattern(pat),
        .sample_div          (div),
        .Bit_Padder_Sel      (pad),
        .arm_pulse           (arm),
        .abort_pulse         (abort),
        .cmd_done            (done),
        .cmd_err             (err),
        .state_debug         (state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Receiver model: a byte leaves the queue and appears on rx_data when unloaded.
    byte unsigned rx_q[$];
    always @(negedge clk) begin
        if (uld === 1'b1) begin
            if (rx_q.size() > 0) rx_data = rx_q.pop_front();
            rx_empty = (rx_q.size() == 0);
        end
    end

    // Pulse monitor
    int   cnt_done = 0, cnt_err = 0, cnt_arm = 0, cnt_abort = 0, cnt_uld = 0;
    logic p_done = 0, p_err = 0, p_arm = 0, p_abort = 0, p_uld = 0;
    always @(negedge clk) begin
        if (done)  begin cnt_done++;  chk("done_width", p_done, 0);   end
        if (err)   begin cnt_err++;   chk("err_width", p_err, 0);     end
        if (abort) begin cnt_abort++; chk("abort_width", p_abort, 0); end
        if (uld)   begin cnt_uld++;   chk("uld_width", p_uld, 0);     end
        if (arm)   begin cnt_arm++;   chk("arm_width", p_arm, 0); chk("arm_abort_excl", abort, 0); end
        p_done = done; p_err = err; p_arm = arm; p_abort = abort; p_uld = uld;
    end

    // Reference model: frame parser over the byte stream.
    int         m_slot = 0;
    logic [7:0] m_cmd = 0, m_data = 0;
    logic [2:0] m_mask = 0;
    logic [7:0] m_pat = 0, m_div = 1;
    logic [1:0] m_pad = 0;
    int         e_done = 0, e_err = 0, e_arm = 0, e_abort = 0, e_uld = 0;

    task automatic model_byte(input logic [7:0] b);
        case (m_slot)
            0: if (b == 8'hA5) m_slot = 1;
            1: begin m_cmd = b; m_slot = 2; end
            2: begin m_data = b; m_slot = 3; end
            default: begin
                m_slot = 0;
                if (b == (m_cmd ^ m_data) && m_cmd >= 1 && m_cmd <= 6) begin
                    e_done++;
                    case (m_cmd)
                        1: m_mask = m_data[2:0];
                        2: m_pat = m_data;
                        3: m_div = (m_data == 0) ? 8'd1 : m_data;
                        4: m_pad = m_data[1:0];
                        5: e_arm++;
                        default: e_abort++;
                    endcase
                end else begin
                    e_err++;
                end
            end
        endcase
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b);
        rx_empty = 1'b0;
        model_byte(b);
        e_uld++;
    endtask

    task automatic wait_idle();
        int stable = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && rx_empty && state == 4'd0) stable++;
            else stable = 0;
            if (stable >= 2) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_state(input logic [3:0] s);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (state == s) return;
        end
        chk("wait_state_timeout", int'(state), int'(s));
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_mask"}, mask, m_mask);
        chk({tag, "_pat"}, pat, m_pat);
        chk({tag, "_div"}, div, m_div);
        chk({tag, "_pad"}, pad, m_pad);
        chk({tag, "_done"}, cnt_done, e_done);
        chk({tag, "_err"}, cnt_err, e_err);
        chk({tag, "_arm"}, cnt_arm, e_arm);
        chk({tag, "_abort"}, cnt_abort, e_abort);
        chk({tag, "_uld"}, cnt_uld, e_uld);
    endtask

    typedef struct packed {
        logic [7:0] b0, b1, b2, b3;
        logic [2:0] mask;
        logic [7:0] pat;
        logic [7:0] div;
        logic [1:0] pad;
        logic [1:0] done, err, arm, abort;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int d0, r0, a0, b0;
        logic [7:0] g, c, d, k;

        tbl[0] = '{8'hA5, 8'h01, 8'h05, 8'h04, 3'd5, 8'h00, 8'h01, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[1] = '{8'hA5, 8'h03, 8'h00, 8'h03, 3'd5, 8'h00, 8'h01, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[2] = '{8'hA5, 8'h03, 8'h10, 8'h13, 3'd5, 8'h00, 8'h10, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[3] = '{8'hA5, 8'h02, 8'h3C, 8'h3F, 3'd5, 8'h00, 8'h10, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
        tbl[4] = '{8'hA5, 8'h02, 8'h3C, 8'h3E, 3'd5, 8'h3C, 8'h10, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[5] = '{8'hA5, 8'h04, 8'hF7, 8'hF3, 3'd5, 8'h3C, 8'h10, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[6] = '{8'hA5, 8'h01, 8'hFA, 8'hFB, 3'd2, 8'h3C, 8'h10, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
        tbl[7] = '{8'hA5, 8'h09, 8'h00, 8'h09, 3'd2, 8'h3C, 8'h10, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
        tbl[8] = '{8'hA5, 8'h06, 8'h00, 8'h06, 3'd2, 8'h3C, 8'h10, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_mask", mask, 0);
        chk("rst_pat", pat, 0);
        chk("rst_div", div, 1);
        chk("rst_pad", pad, 0);
        chk("rst_rx_en", rx_en, 1);
        chk("rst_uld", uld, 0);
        chk("rst_pulses", {done, err, arm, abort}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frame table
        for (int i = 0; i < 9; i++) begin
            d0 = cnt_done; r0 = cnt_err; a0 = cnt_arm; b0 = cnt_abort;
            push_byte(tbl[i].b0); push_byte(tbl[i].b1);
            push_byte(tbl[i].b2); push_byte(tbl[i].b3);
            wait_idle();
            chk($sformatf("vec%0d_mask", i), mask, tbl[i].mask);
            chk($sformatf("vec%0d_pat", i), pat, tbl[i].pat);
            chk($sformatf("vec%0d_div", i), div, tbl[i].div);
            chk($sformatf("vec%0d_pad", i), pad, tbl[i].pad);
            chk($sformatf("vec%0d_done", i), cnt_done - d0, tbl[i].done);
            chk($sformatf("vec%0d_err", i), cnt_err - r0, tbl[i].err);
            chk($sformatf("vec%0d_arm", i), cnt_arm - a0, tbl[i].arm);
            chk($sformatf("vec%0d_abort", i), cnt_abort - b0, tbl[i].abort);
        end
        chk("table_uld", cnt_uld, e_uld);

        // Garbage bytes are dropped silently, then one arm
        r0 = cnt_err; a0 = cnt_arm;
        push_byte(8'h00); push_byte(8'hFF);
        push_byte(8'hA5); push_byte(8'h05); push_byte(8'h00); push_byte(8'h05);
        wait_idle();
        chk("garbage_no_err", cnt_err - r0, 0);
        chk("garbage_arm", cnt_arm - a0, 1);

        // CHK latency: cmd_done three cycles after rx_empty falls
        push_byte(8'hA5); push_byte(8'h01); push_byte(8'h02);
        wait_state(4'd5);
        push_byte(8'h03);
        @(negedge clk);
        chk("lat_c1_uld", uld, 1);
        chk("lat_c1_done", done, 0);
        @(negedge clk);
        chk("lat_c2_done", done, 0);
        @(negedge clk);
        chk("lat_c3_done", done, 1);
        wait_idle();
        chk("lat_mask", mask, 2);

        // Inter-byte timeout
        push_byte(8'hA5); push_byte(8'h04);
        wait_state(4'd4);
        begin
            int k_cyc = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                k_cyc++;
                if (err) break;
            end
            chk("tmo_cycles", k_cyc, TMO);
        end
        m_slot = 0;
        e_err++;
        @(negedge clk);
        chk("tmo_state_idle", state, 0);
        push_byte(8'hA5); push_byte(8'h04); push_byte(8'h02); push_byte(8'h06);
        wait_idle();
        chk_model("after_tmo");

        // Asynchronous reset between DATA and CHK
        push_byte(8'hA5); push_byte(8'h01); push_byte(8'h07);
        wait_state(4'd5);
        d0 = cnt_done; r0 = cnt_err;
        #2 rst = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_mask", mask, 0);
        chk("arst_pat", pat, 0);
        chk("arst_div", div, 1);
        chk("arst_pad", pad, 0);
        chk("arst_rx_en", rx_en, 1);
        m_slot = 0; m_mask = 0; m_pat = 0; m_div = 1; m_pad = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_byte(8'h06);
        wait_idle();
        chk("arst_no_done", cnt_done - d0, 0);
        chk("arst_no_err", cnt_err - r0, 0);
        chk("arst_mask_kept", mask, 0);

        // Random frame stream
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                push_byte(g);
            end
            c = 8'($urandom_range(0, 8));
            d = 8'($urandom_range(0, 255));
            k = c ^ d;
            if ($urandom_range(0, 4) == 0) k = k ^ (8'h01 << $urandom_range(0, 7));
            push_byte(8'hA5);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            push_byte(c);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            push_byte(d);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            push_byte(k);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if (f % 20 == 19) begin
                wait_idle();
                chk_model($sformatf("rand%0d", f));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
